insn_prefetch: RTL and testbench
================================

Name: insn_prefetch

Overview:
- Sequential instruction prefetch buffer between the core's fetch stage and the SoC external memory port (ext_mem_valid/ready/addr/rdata).
- Issues word reads at consecutive addresses and queues the returned words with their addresses in a small FIFO.
- Hands instructions to the core over a valid/ready interface.
- Core branches redirect the fetch stream: the FIFO is flushed and any in-flight response is discarded.

Parameters:
- ADDR_W, 8, word-address width of the external memory port
- DATA_W, 32, instruction word width
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- redirect_valid  input  1  single-cycle pulse: restart fetch at redirect_addr
- redirect_addr  input  ADDR_W  new fetch word address
- insn_valid  output  1  FIFO head holds a valid instruction
- insn_ready  input  1  core accepts the head this cycle
- insn_data  output  DATA_W  head instruction word
- insn_addr  output  ADDR_W  word address of the head instruction
- ext_mem_valid  output  1  read request to external memory
- ext_mem_ready  input  1  response strobe; ext_mem_rdata is valid in the same cycle
- ext_mem_addr  output  ADDR_W  request word address
- ext_mem_rdata  input  DATA_W  response data

Behaviour:
- Reset (sync, active-high; dominates every other input):
  - ext_mem_valid=0, ext_mem_addr=0, insn_valid=0, insn_data=0, insn_addr=0.
  - fetch_addr=0, FIFO empty, no request pending, drop flag clear.
- Request issue (all outputs registered):
  - At most one request outstanding at a time.
  - A new request is issued when no request is pending and count + pending < DEPTH.
  - On issue: ext_mem_valid<=1, ext_mem_addr<=fetch_addr, fetch_addr<=fetch_addr+1 (mod 2^ADDR_W; 0xFF wraps to 0x00).
  - ext_mem_valid and ext_mem_addr are held stable until ext_mem_ready is sampled high.
- Completion (ext_mem_ready=1 with a request pending):
  - Push {ext_mem_addr, ext_mem_rdata} into the FIFO, unless the drop flag is set; in that case discard the response and clear the flag.
  - In the same edge, the next request may be issued (ext_mem_valid stays 1 with the new address) if the issue condition holds; otherwise ext_mem_valid<=0.
- Stray ready: ext_mem_ready with no request pending is ignored.
- Output side:
  - insn_valid = FIFO not empty; insn_data and insn_addr show the head entry.
  - insn_valid && insn_ready pops one entry.
  - A push and a pop in the same cycle leave count unchanged.
  - Storage is written only on push.
- Latency: an ext_mem_ready sampled in cycle N gives insn_valid with that word in cycle N+1. There is no bypass.
- FIFO full: count == DEPTH, or count + pending == DEPTH, means no new issue. Issue resumes on the cycle after a pop frees a slot.
- Redirect (redirect_valid=1):
  - FIFO flushed: insn_valid=0 next cycle.
  - fetch_addr <= redirect_addr.
  - A pop in the same cycle is ignored; redirect wins.
  - If a request is pending and ext_mem_ready=0, the drop flag is set. The request stays on the bus unchanged until its ready; the request at redirect_addr issues after that ready.
  - If ext_mem_ready=1 in the redirect cycle, the response is discarded, ext_mem_valid<=0, and the request at redirect_addr issues the following cycle.
  - If no request is pending, the request at redirect_addr issues at the same edge.
  - A second redirect while the drop flag is already set only updates fetch_addr.
- Reset mid-request: pending request abandoned, drop flag cleared, all outputs at reset values next cycle. A late ext_mem_ready is treated as a stray ready.

Test Plan:
1. mem[i]=0xA0000000+i, insn_ready=1, rst pulsed -> ext_mem_valid rises the first cycle after rst falls with addr 0; insn_addr/insn_data stream 0/0xA0000000, 1/0xA0000001, ... in order. Against a one-cycle-ready memory, one word every 2 cycles.
2. insn_ready=0 -> exactly 4 requests (addr 0..3), then ext_mem_valid stays 0. Raise insn_ready for 1 cycle -> addr 0 popped, and a request at addr 4 is issued the next cycle.
3. Redirect to 0x40 while the request at addr 2 is pending -> ext_mem_addr holds 2 until ready; that word never appears on insn_*. Next request is 0x40; first insn_addr after the redirect is 0x40.
4. redirect_valid, ext_mem_ready and insn_valid&&insn_ready all in the same cycle -> insn_valid=0 next cycle, response discarded, ext_mem_addr=redirect target the cycle after.
5. Redirect to 0xFE -> request addresses FE, FF, 00, 01; insn_addr matches in order.
6. rst asserted while ext_mem_valid=1, then a stray ext_mem_ready after rst falls -> all outputs 0 during reset; the stray ready pushes nothing; the next request is addr 0.

Source files
------------

// File: rtl/insn_prefetch.sv
// Sequential instruction prefetch buffer. It issues one external word read at a time
// into a small FIFO and presents the FIFO head, registered, to the core's fetch stage.
module insn_prefetch #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [DATA_W-1:0] insn_data,
  output logic [ADDR_W-1:0] insn_addr,
  output logic              ext_mem_valid,
  input  logic              ext_mem_ready,
  output logic [ADDR_W-1:0] ext_mem_addr,
  input  logic [DATA_W-1:0] ext_mem_rdata
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = ADDR_W + DATA_W;

  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W:0]    count;
  logic [ADDR_W-1:0] fetch_addr;
  logic              drop;

  logic              complete;
  logic              push;
  logic              pop;
  logic [PTR_W:0]    count_next;
  logic              can_issue;
  logic [PTR_W-1:0]  head_idx;
  logic              head_from_push;
  logic [ENT_W-1:0]  head_next;

  // ext_mem_valid doubles as the "request pending" flag.
  always_comb begin
    complete       = ext_mem_valid && ext_mem_ready;
    push           = complete && !drop && !redirect_valid;
    pop            = insn_valid && insn_ready && !redirect_valid;
    count_next     = count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    can_issue      = (!ext_mem_valid || complete) && (count_next < (PTR_W+1)'(DEPTH));
    head_idx       = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
    // When nothing older survives this edge, the new head is the word arriving now.
    head_from_push = push && (count == (PTR_W+1)'(pop));
    head_next      = head_from_push ? {ext_mem_addr, ext_mem_rdata} : mem[head_idx];
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= {ext_mem_addr, ext_mem_rdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      fetch_addr    <= '0;
      drop          <= 1'b0;
      insn_valid    <= 1'b0;
      insn_data     <= '0;
      insn_addr     <= '0;
      ext_mem_valid <= 1'b0;
      ext_mem_addr  <= '0;
    end else if (redirect_valid) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      insn_valid <= 1'b0;
      fetch_addr <= redirect_addr;
      if (ext_mem_valid && !ext_mem_ready) begin
        // Leave the stale request on the bus and throw its data away when it lands.
        drop <= 1'b1;
      end else if (complete) begin
        drop          <= 1'b0;
        ext_mem_valid <= 1'b0;
      end else begin
        ext_mem_valid <= 1'b1;
        ext_mem_addr  <= redirect_addr;
        fetch_addr    <= redirect_addr + ADDR_W'(1);
      end
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count      <= count_next;
      insn_valid <= (count_next != '0);
      if ((push || pop) && (count_next != '0)) begin
        {insn_addr, insn_data} <= head_next;
      end
      if (complete) begin
        drop <= 1'b0;
      end
      if (can_issue) begin
        ext_mem_valid <= 1'b1;
        ext_mem_addr  <= fetch_addr;
        fetch_addr    <= fetch_addr + ADDR_W'(1);
      end else if (complete) begin
        ext_mem_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_insn_prefetch.sv
// Bench for insn_prefetch: directed scenarios plus random traffic, all compared every
// cycle against a queue-based behavioural model of the prefetcher.
module tb_insn_prefetch;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_addr = '0;
  logic              insn_valid;
  logic              insn_ready = 1'b0;
  logic [DATA_W-1:0] insn_data;
  logic [ADDR_W-1:0] insn_addr;
  logic              ext_mem_valid;
  logic              ext_mem_ready = 1'b0;
  logic [ADDR_W-1:0] ext_mem_addr;
  logic [DATA_W-1:0] ext_mem_rdata = '0;

  always #5 clk = ~clk;

  insn_prefetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .insn_valid    (insn_valid),
    .insn_ready    (insn_ready),
    .insn_data     (insn_data),
    .insn_addr     (insn_addr),
    .ext_mem_valid (ext_mem_valid),
    .ext_mem_ready (ext_mem_ready),
    .ext_mem_addr  (ext_mem_addr),
    .ext_mem_rdata (ext_mem_rdata)
  );

  int tests = 0;
  int fails = 0;

  logic [DATA_W-1:0] mem [256];

  // Reference model: FIFO contents as queues, plus the fetch pointer and request state.
  logic [ADDR_W-1:0] qa [$];
  logic [DATA_W-1:0] qd [$];
  bit                m_pend;
  bit                m_drop;
  bit                m_zero;
  logic [ADDR_W-1:0] m_fa;
  logic [ADDR_W-1:0] m_ma;
  int                m_age;

  int                valid_cycles;
  bit                rec_en;
  logic [ADDR_W-1:0] rec [$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_issue(input logic [ADDR_W-1:0] a);
    m_pend = 1'b1;
    m_ma   = a;
    m_fa   = a + ADDR_W'(1);
    m_age  = 0;
  endtask

  task automatic model_step();
    bit comp;
    bit do_pop;
    m_zero = 1'b0;
    if (rst) begin
      qa.delete();
      qd.delete();
      m_pend = 1'b0;
      m_drop = 1'b0;
      m_fa   = '0;
      m_ma   = '0;
      m_age  = 0;
      m_zero = 1'b1;
      return;
    end
    comp = m_pend && ext_mem_ready;
    if (redirect_valid) begin
      qa.delete();
      qd.delete();
      if (m_pend && !ext_mem_ready) begin
        m_drop = 1'b1;
        m_fa   = redirect_addr;
        m_age++;
      end else if (comp) begin
        m_pend = 1'b0;
        m_drop = 1'b0;
        m_fa   = redirect_addr;
      end else begin
        model_issue(redirect_addr);
      end
      return;
    end
    do_pop = (qa.size() > 0) && insn_ready;
    if (do_pop) begin
      $display("[TB] insn addr=%02h data=%08h", qa[0], qd[0]);
      void'(qa.pop_front());
      void'(qd.pop_front());
    end
    if (comp) begin
      if (m_drop) m_drop = 1'b0;
      else begin
        qa.push_back(m_ma);
        qd.push_back(ext_mem_rdata);
      end
      m_pend = 1'b0;
    end
    if (!m_pend && qa.size() < DEPTH) model_issue(m_fa);
    else if (m_pend) m_age++;
  endtask

  task automatic compare();
    check_eq("ext_mem_valid", 64'(ext_mem_valid), 64'(m_pend));
    if (m_pend || m_zero) check_eq("ext_mem_addr", 64'(ext_mem_addr), 64'(m_ma));
    check_eq("insn_valid", 64'(insn_valid), 64'(qa.size() > 0));
    if (qa.size() > 0) begin
      check_eq("insn_addr", 64'(insn_addr), 64'(qa[0]));
      check_eq("insn_data", 64'(insn_data), 64'(qd[0]));
    end else if (m_zero) begin
      check_eq("insn_addr_rst", 64'(insn_addr), 64'(0));
      check_eq("insn_data_rst", 64'(insn_data), 64'(0));
    end
    if (insn_valid) begin
      valid_cycles++;
      if (rec_en) rec.push_back(insn_addr);
    end
  endtask

  task automatic cycle(input bit r, input bit rv, input logic [ADDR_W-1:0] ra,
                       input bit ir, input bit mr);
    rst            = r;
    redirect_valid = rv;
    redirect_addr  = ra;
    insn_ready     = ir;
    ext_mem_ready  = mr;
    ext_mem_rdata  = (mr && m_pend) ? mem[m_ma] : DATA_W'($urandom);
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  // Memory that answers a request once it has been visible for lat cycles.
  task automatic auto_cycle(input int lat, input bit ir);
    cycle(1'b0, 1'b0, '0, ir, m_pend && (m_age >= lat));
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + DATA_W'(i);
    @(negedge clk);

    // 1: streaming from a one-cycle-ready memory.
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_eq("t1_first_req_valid", 64'(ext_mem_valid), 64'(1));
    check_eq("t1_first_req_addr", 64'(ext_mem_addr), 64'(0));
    for (int i = 0; i < 10; i++) auto_cycle(1, 1'b1);
    valid_cycles = 0;
    for (int i = 0; i < 20; i++) auto_cycle(1, 1'b1);
    check_eq("t1_rate", 64'(valid_cycles), 64'(10));

    // 2: core stalled, FIFO fills, then one pop restarts issue.
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) auto_cycle(1, 1'b0);
    check_eq("t2_idle", 64'(ext_mem_valid), 64'(0));
    check_eq("t2_head_addr", 64'(insn_addr), 64'(0));
    check_eq("t2_head_data", 64'(insn_data), 64'(32'hA000_0000));
    auto_cycle(1, 1'b1);
    check_eq("t2_resume_valid", 64'(ext_mem_valid), 64'(1));
    check_eq("t2_resume_addr", 64'(ext_mem_addr), 64'(4));

    // 3: redirect while the request at 2 is still waiting.
    cycle(1'b1, 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 30 && !(m_pend && m_ma == 8'd2); i++) auto_cycle(3, 1'b1);
    check_eq("t3_pre_addr", 64'(ext_mem_addr), 64'(2));
    cycle(1'b0, 1'b1, 8'h40, 1'b1, 1'b0);
    check_eq("t3_hold_addr", 64'(ext_mem_addr), 64'(2));
    check_eq("t3_hold_valid", 64'(ext_mem_valid), 64'(1));
    for (int i = 0; i < 40 && !insn_valid; i++) auto_cycle(1, 1'b0);
    check_eq("t3_seen", 64'(insn_valid), 64'(1));
    check_eq("t3_first_addr", 64'(insn_addr), 64'(8'h40));

    // 4: redirect, response and pop all in one cycle.
    for (int i = 0; i < 10 && !m_pend; i++) auto_cycle(9, 1'b0);
    cycle(1'b0, 1'b1, 8'h80, 1'b1, 1'b1);
    check_eq("t4_flush", 64'(insn_valid), 64'(0));
    check_eq("t4_req_dropped", 64'(ext_mem_valid), 64'(0));
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
    check_eq("t4_new_valid", 64'(ext_mem_valid), 64'(1));
    check_eq("t4_new_addr", 64'(ext_mem_addr), 64'(8'h80));

    // 5: address wrap after a redirect near the top.
    cycle(1'b0, 1'b1, 8'hFE, 1'b1, 1'b0);
    rec.delete();
    rec_en = 1'b1;
    for (int i = 0; i < 30; i++) auto_cycle(1, 1'b1);
    rec_en = 1'b0;
    check_eq("t5_count", 64'(rec.size() >= 4), 64'(1));
    if (rec.size() >= 4) begin
      check_eq("t5_addr0", 64'(rec[0]), 64'(8'hFE));
      check_eq("t5_addr1", 64'(rec[1]), 64'(8'hFF));
      check_eq("t5_addr2", 64'(rec[2]), 64'(8'h00));
      check_eq("t5_addr3", 64'(rec[3]), 64'(8'h01));
    end

    // 6: reset in the middle of a request, then a stray ready.
    for (int i = 0; i < 10 && !m_pend; i++) auto_cycle(9, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    check_eq("t6_rst_valid", 64'(ext_mem_valid), 64'(0));
    check_eq("t6_rst_addr", 64'(ext_mem_addr), 64'(0));
    check_eq("t6_rst_insn", 64'(insn_valid), 64'(0));
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b1);
    check_eq("t6_next_addr", 64'(ext_mem_addr), 64'(0));
    cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
    check_eq("t6_no_push", 64'(insn_valid), 64'(0));

    // Random traffic against the model.
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    cycle(1'b1, 1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 2000; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 8'hFC + ADDR_W'($urandom_range(0, 3))
                                       : ADDR_W'($urandom);
      cycle($urandom_range(0, 299) == 0,
            $urandom_range(0, 24) == 0,
            ra,
            $urandom_range(0, 2) != 0,
            m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
